// File: rtl/intc_pkg.sv
// ============================================================================
// Module  : intc_pkg
// Brief   : Shared constants and FSM state type for the intc_multi controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package intc_pkg;

    localparam int MAX_CH = 16;
    localparam int ID_W   = $clog2(MAX_CH);

    localparam logic [31:0] OFF_TABLE  = 32'h0000_0000;
    localparam logic [31:0] OFF_ENABLE = 32'h0000_0040;
    localparam logic [31:0] OFF_PEND   = 32'h0000_0044;
    localparam logic [31:0] OFF_OVR    = 32'h0000_0048;
    localparam logic [31:0] OFF_ACTIVE = 32'h0000_004C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } intc_state_t;

endpackage

`default_nettype wire

// File: rtl/intc_arbiter.sv
// ============================================================================
// Module  : intc_arbiter
// Brief   : Combinational pick among requests: highest index, or round-robin.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_arbiter
    import intc_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [ID_W-1:0]   i_ptr,
    input  logic              i_rr_mode,
    output logic [ID_W-1:0]   o_grant_id,
    output logic              o_grant_valid
);

    logic [ID_W:0] w_idx;

    always_comb begin
        o_grant_id    = '0;
        o_grant_valid = |i_req;
        w_idx         = '0;
        if (i_rr_mode) begin
            // Walk the offsets downwards so the smallest offset from the pointer wins.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                w_idx = {1'b0, i_ptr} + (ID_W + 1)'(k);
                if (w_idx >= (ID_W + 1)'(NUM_CH)) begin
                    w_idx = w_idx - (ID_W + 1)'(NUM_CH);
                end
                for (int j = 0; j < NUM_CH; j++) begin
                    if ((w_idx == (ID_W + 1)'(j)) && i_req[j]) begin
                        o_grant_id = ID_W'(j);
                    end
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_req[i]) begin
                    o_grant_id = ID_W'(i);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intc_multi.sv
// ============================================================================
// Module  : intc_multi
// Brief   : Memory-mapped NUM_CH-source interrupt controller with IRQ/IACK handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_multi
    import intc_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          RR_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] done,
    input  logic              IACK,
    input  logic [31:0]       input_addr,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              IRQ,
    output logic [DATA_W-1:0] isr_addr,
    output logic              error
);

    intc_state_t       r_state, w_state_nxt;
    logic [DATA_W-1:0] r_table [NUM_CH];
    logic [NUM_CH-1:0] r_enable, r_pend, r_ovr;
    logic [ID_W-1:0]   r_act_id, w_act_id_nxt;
    logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [DATA_W-1:0] r_isr, w_isr_nxt;
    logic              r_error;

    logic [31:0]       w_off, w_tab_off;
    logic              w_tab_hit, w_wr_en, w_wr_pend, w_wr_ovr;
    logic [ID_W-1:0]   w_tab_idx;
    logic [DATA_W-1:0] w_tab_rd, w_tab_grant;
    logic [ID_W-1:0]   w_grant_id;
    logic              w_grant_valid;
    logic              w_retire;
    logic [NUM_CH-1:0] w_retire_mask, w_clr, w_ovr_clr, w_ovr_set;

    // ---------------- bus decode ----------------
    assign w_off     = input_addr - BASE_ADDR;
    assign w_tab_off = w_off - OFF_TABLE;
    assign w_tab_hit = (w_tab_off < 32'(4 * NUM_CH)) && (w_tab_off[1:0] == 2'b00);
    assign w_tab_idx = w_tab_off[ID_W+1:2];
    assign w_wr_en   = write_enable && (w_off == OFF_ENABLE);
    assign w_wr_pend = write_enable && (w_off == OFF_PEND);
    assign w_wr_ovr  = write_enable && (w_off == OFF_OVR);

    always_comb begin
        w_tab_rd    = '0;
        w_tab_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_tab_idx == ID_W'(i)) begin
                w_tab_rd = r_table[i];
            end
            if (w_grant_id == ID_W'(i)) begin
                w_tab_grant = r_table[i];
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (w_tab_hit) begin
            read_data = w_tab_rd;
        end else if (w_off == OFF_ENABLE) begin
            read_data[NUM_CH-1:0] = r_enable;
        end else if (w_off == OFF_PEND) begin
            read_data[NUM_CH-1:0] = r_pend;
        end else if (w_off == OFF_OVR) begin
            read_data[NUM_CH-1:0] = r_ovr;
        end else if (w_off == OFF_ACTIVE) begin
            read_data[ID_W-1:0] = r_act_id;
            read_data[DATA_W-1] = (r_state == ST_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_table[i] <= '0;
            end
        end else if (write_enable && w_tab_hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_tab_idx == ID_W'(i)) begin
                    r_table[i] <= write_data;
                end
            end
        end
    end

    // ---------------- pending / overrun ----------------
    // A bit counts as "being cleared" by either the IACK retire or a W1C; done still wins.
    assign w_retire      = (r_state == ST_REQ) && IACK;
    assign w_retire_mask = w_retire ? (NUM_CH'(1) << r_act_id) : '0;
    assign w_clr         = w_retire_mask | (w_wr_pend ? write_data[NUM_CH-1:0] : '0);
    assign w_ovr_clr     = w_wr_ovr ? write_data[NUM_CH-1:0] : '0;
    assign w_ovr_set     = done & r_pend & ~w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= '1;
            r_pend   <= '0;
            r_ovr    <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_enable <= write_data[NUM_CH-1:0];
            end
            r_pend  <= (r_pend & ~w_clr) | done;
            r_ovr   <= (r_ovr & ~w_ovr_clr) | w_ovr_set;
            r_error <= |w_ovr_set;
        end
    end

    // ---------------- arbitration and handshake FSM ----------------
    intc_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .i_req         (r_pend & r_enable),
        .i_ptr         (r_rr_ptr),
        .i_rr_mode     (RR_MODE != 0),
        .o_grant_id    (w_grant_id),
        .o_grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_act_id <= '0;
            r_rr_ptr <= '0;
            r_isr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_act_id <= w_act_id_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_isr    <= w_isr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_act_id_nxt = r_act_id;
        w_rr_ptr_nxt = r_rr_ptr;
        w_isr_nxt    = r_isr;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt  = ST_REQ;
                    w_act_id_nxt = w_grant_id;
                    w_isr_nxt    = w_tab_grant;
                end
            end
            ST_REQ: begin
                if (IACK) begin
                    w_state_nxt  = ST_WAIT;
                    w_rr_ptr_nxt = (r_act_id == ID_W'(NUM_CH - 1)) ? '0 : r_act_id + ID_W'(1);
                end
            end
            ST_WAIT: begin
                // Requiring IACK low here is what limits one acknowledge to one retire.
                if (!IACK) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign IRQ      = (r_state == ST_REQ);
    assign isr_addr = r_isr;
    assign error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_intc_multi.sv
// ============================================================================
// Module  : tb_intc_multi
// Brief   : Scoreboard bench driving a fixed-priority and a round-robin instance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_intc_multi;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] A_EN = BASE + 32'h40;
    localparam logic [31:0] A_PD = BASE + 32'h44;
    localparam logic [31:0] A_OV = BASE + 32'h48;
    localparam logic [31:0] A_AC = BASE + 32'h4C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] done = '0;
    logic         IACK = 1'b0;
    logic [31:0]  input_addr = '0;
    logic         write_enable = 1'b0;
    logic [31:0]  write_data = '0;
    logic [31:0]  rd_f, rd_r, isr_f, isr_r;
    logic         irq_f, irq_r, err_f, err_r;

    always #5 clk = ~clk;

    intc_multi #(.NUM_CH(N), .DATA_W(32), .BASE_ADDR(BASE), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .done(done), .IACK(IACK), .input_addr(input_addr),
        .write_enable(write_enable), .write_data(write_data), .read_data(rd_f),
        .IRQ(irq_f), .isr_addr(isr_f), .error(err_f));

    intc_multi #(.NUM_CH(N), .DATA_W(32), .BASE_ADDR(BASE), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .done(done), .IACK(IACK), .input_addr(input_addr),
        .write_enable(write_enable), .write_data(write_data), .read_data(rd_r),
        .IRQ(irq_r), .isr_addr(isr_r), .error(err_r));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model; index 0 = fixed-priority instance, 1 = round-robin instance.
    logic [31:0]  m_tab [N];
    logic [N-1:0] m_en;
    logic [N-1:0] m_pend [2];
    logic [N-1:0] m_ovr  [2];
    int           m_phase [2];   // 0 idle, 1 requesting, 2 waiting for IACK low
    int           m_act   [2];
    int           m_ptr   [2];
    logic [31:0]  m_isr   [2];

    typedef struct packed {
        logic [1:0]  irq;
        logic [1:0]  err;
        logic [31:0] isr0;
        logic [31:0] isr1;
    } out_t;

    typedef struct packed {
        logic [31:0] e0;
        logic [31:0] e1;
    } rd_t;

    out_t q_out [$];
    rd_t  q_rd  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_tab[i] = '0;
        m_en = '1;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_ovr[m] = '0; m_phase[m] = 0;
            m_act[m] = 0; m_ptr[m] = 0; m_isr[m] = '0;
        end
    endfunction

    function automatic int pick(input int m, input logic [N-1:0] req);
        if (m == 0) begin
            for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr[m] + k) % N;
                if (req[c]) return c;
            end
        end
        return -1;
    endfunction

    function automatic logic [31:0] rd_model(input int m, input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] r;
        off = a - BASE;
        r   = '0;
        if (off < 32'(4 * N) && off[1:0] == 2'b00) r = m_tab[int'(off >> 2)];
        else if (off == 32'h40) r[N-1:0] = m_en;
        else if (off == 32'h44) r[N-1:0] = m_pend[m];
        else if (off == 32'h48) r[N-1:0] = m_ovr[m];
        else if (off == 32'h4C) begin
            r[3:0] = 4'(m_act[m]);
            r[31]  = (m_phase[m] == 1);
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        out_t         o;
        logic [31:0]  off;
        logic [N-1:0] old_pend;
        logic         clr;
        int           g;
        o = '0;
        if (!rst_n) begin
            model_reset();
        end else begin
            off = input_addr - BASE;
            for (int m = 0; m < 2; m++) begin
                old_pend = m_pend[m];
                for (int i = 0; i < N; i++) begin
                    clr = (m_phase[m] == 1 && IACK && m_act[m] == i) ||
                          (write_enable && off == 32'h44 && write_data[i]);
                    if (done[i] && old_pend[i] && !clr) begin
                        m_ovr[m][i] = 1'b1;
                        o.err[m]    = 1'b1;
                    end else if (write_enable && off == 32'h48 && write_data[i]) begin
                        m_ovr[m][i] = 1'b0;
                    end
                    if (done[i]) m_pend[m][i] = 1'b1;
                    else if (clr) m_pend[m][i] = 1'b0;
                end
                if (m_phase[m] == 0) begin
                    g = pick(m, old_pend & m_en);
                    if (g >= 0) begin
                        m_act[m] = g; m_isr[m] = m_tab[g]; m_phase[m] = 1;
                    end
                end else if (m_phase[m] == 1) begin
                    if (IACK) begin
                        m_phase[m] = 2; m_ptr[m] = (m_act[m] + 1) % N;
                    end
                end else if (!IACK) begin
                    m_phase[m] = 0;
                end
            end
            if (write_enable) begin
                if (off < 32'(4 * N) && off[1:0] == 2'b00) m_tab[int'(off >> 2)] = write_data;
                if (off == 32'h40) m_en = write_data[N-1:0];
            end
        end
        o.irq  = {m_phase[1] == 1, m_phase[0] == 1};
        o.isr0 = m_isr[0];
        o.isr1 = m_isr[1];
        q_out.push_back(o);
    endtask

    // One bus cycle, called at a falling edge; read_data is checked against the model.
    task automatic cyc(input logic [N-1:0] d, input logic ack, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
        rd_t r;
        done = d; IACK = ack; write_enable = we; input_addr = a; write_data = wd;
        r.e0 = rd_model(0, a);
        r.e1 = rd_model(1, a);
        q_rd.push_back(r);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // One idle cycle reading an address whose value is known from the scenario.
    task automatic rdc(input logic [31:0] a, input logic [31:0] e);
        rd_t r;
        done = '0; IACK = 1'b0; write_enable = 1'b0; input_addr = a; write_data = '0;
        r.e0 = e;
        r.e1 = e;
        q_rd.push_back(r);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b0, 1'b0, A_AC, '0);
    endtask

    task automatic ack();
        cyc('0, 1'b1, 1'b0, A_PD, '0);
        cyc('0, 1'b0, 1'b0, A_PD, '0);
    endtask

    always @(negedge clk) begin
        out_t e;
        rd_t  r;
        #2;
        if (q_out.size() != 0) begin
            e = q_out.pop_front();
            chk("irq_fix", {31'b0, irq_f}, {31'b0, e.irq[0]});
            chk("irq_rr",  {31'b0, irq_r}, {31'b0, e.irq[1]});
            chk("err_fix", {31'b0, err_f}, {31'b0, e.err[0]});
            chk("err_rr",  {31'b0, err_r}, {31'b0, e.err[1]});
            chk("isr_fix", isr_f, e.isr0);
            chk("isr_rr",  isr_r, e.isr1);
        end
        if (q_rd.size() != 0) begin
            r = q_rd.pop_front();
            chk("rd_fix", rd_f, r.e0);
            chk("rd_rr",  rd_r, r.e1);
        end
    end

    logic [31:0] addr_pool [8];

    initial begin
        logic [N-1:0] d;
        logic [31:0]  a;
        logic [31:0]  wd;
        model_reset();
        @(negedge clk);
        rdc(A_EN, 32'hF);
        rdc(A_PD, 32'h0);
        rdc(BASE, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) cyc('0, 1'b0, 1'b1, BASE + 32'(4 * i), 32'hA + 32'(i));
        for (int i = 0; i < N; i++) rdc(BASE + 32'(4 * i), 32'hA + 32'(i));
        rdc(BASE + 32'h50, 32'h0);

        // single sources, then a simultaneous pair
        cyc(4'b1000, 1'b0, 1'b0, A_AC, '0); idle(3); ack(); rdc(A_PD, 32'h0);
        cyc(4'b0100, 1'b0, 1'b0, A_AC, '0); idle(3); ack();
        cyc(4'b0101, 1'b0, 1'b0, A_AC, '0); idle(3); ack(); idle(3); ack();
        rdc(A_PD, 32'h0);

        // masked source
        cyc('0, 1'b0, 1'b1, A_EN, 32'hD);
        cyc(4'b0010, 1'b0, 1'b0, A_AC, '0); idle(3);
        rdc(A_PD, 32'h2);
        cyc(4'b0010, 1'b0, 1'b1, A_PD, 32'h2);
        rdc(A_PD, 32'h2);
        cyc('0, 1'b0, 1'b1, A_PD, 32'h2);
        rdc(A_PD, 32'h0);
        cyc(4'b0010, 1'b0, 1'b0, A_AC, '0);
        cyc('0, 1'b0, 1'b1, A_EN, 32'hF); idle(3); ack();

        // overrun on a repeated done
        cyc(4'b0100, 1'b0, 1'b0, A_AC, '0); idle(1);
        cyc(4'b0100, 1'b0, 1'b0, A_AC, '0); idle(2);
        rdc(A_OV, 32'h4);
        cyc('0, 1'b0, 1'b1, A_OV, 32'h4);
        rdc(A_OV, 32'h0);
        ack();

        // table write during REQ, done on the retiring channel
        cyc(4'b1000, 1'b0, 1'b0, A_AC, '0); idle(3);
        rdc(A_AC, 32'h8000_0003);
        cyc('0, 1'b0, 1'b1, BASE + 32'hC, 32'h55); idle(1);
        cyc(4'b1000, 1'b1, 1'b0, A_PD, '0);
        cyc('0, 1'b0, 1'b0, A_PD, '0); idle(3); ack();
        rdc(A_OV, 32'h0);

        // IACK held across two pending channels
        cyc(4'b0011, 1'b0, 1'b0, A_AC, '0); idle(3);
        repeat (4) cyc('0, 1'b1, 1'b0, A_PD, '0);
        cyc('0, 1'b0, 1'b0, A_PD, '0); idle(3); ack();

        // disable and clear the active channel, then reset while requesting
        cyc(4'b0001, 1'b0, 1'b0, A_AC, '0); idle(3);
        cyc('0, 1'b0, 1'b1, A_EN, 32'h0);
        cyc('0, 1'b0, 1'b1, A_PD, 32'h1); idle(2);
        cyc(4'b0110, 1'b0, 1'b0, A_PD, '0);
        rst_n = 1'b0;
        model_reset();
        q_out.delete();
        q_out.push_back('0);
        rdc(A_EN, 32'hF);
        rdc(A_PD, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) cyc('0, 1'b0, 1'b1, BASE + 32'(4 * i), 32'h100 + 32'(i));

        // randomized traffic
        addr_pool[0] = BASE;          addr_pool[1] = BASE + 32'h8;
        addr_pool[2] = A_EN;          addr_pool[3] = A_PD;
        addr_pool[4] = A_OV;          addr_pool[5] = A_AC;
        addr_pool[6] = BASE + 32'h50; addr_pool[7] = BASE + 32'h41;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 7) == 0);
            a = addr_pool[$urandom_range(0, 7)];
            if (a == BASE && $urandom_range(0, 1) == 1) a = BASE + 32'(4 * $urandom_range(0, N - 1));
            wd = $urandom;
            if (a == A_EN && $urandom_range(0, 2) != 0) wd = 32'hF;
            cyc(d, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, a, wd);
        end
        idle(4);
        #5;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intc_multi.md
# intc_multi

Parametrised successor to the four-channel interrupt controller. It latches completion pulses from `NUM_CH` accelerator units into pending bits and arbitrates among enabled pending channels using fixed or round-robin priority. It raises `IRQ` toward the MIPS core with the selected channel's ISR address, and retires the request on `IACK`. It is memory-mapped on the CPU data bus and adds an enable mask, pending/overrun status and an active-channel register.

## Interface
Parameters:
- `NUM_CH`, 4, number of interrupt sources (1..16)
- `DATA_W`, 32, bus data and ISR address width
- `BASE_ADDR`, 32'h0000_2000, register block base
- `RR_MODE`, 0, 0 = fixed priority (highest index wins), 1 = round-robin

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `done` in NUM_CH: completion pulses from factorial units
- `IACK` in 1: interrupt acknowledge from CPU
- `input_addr` in 32: bus address
- `write_enable` in 1: bus write strobe
- `write_data` in DATA_W: bus write data
- `read_data` out DATA_W: combinational read of the addressed register; 0 if unmapped
- `IRQ` out 1: interrupt request
- `isr_addr` out DATA_W: ISR address of the active channel; stable while `IRQ`=1
- `error` out 1: one-cycle pulse on any overrun

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x00+4i: ISR address table entry i, RW.
  - 0x40: enable mask [NUM_CH-1:0], RW.
  - 0x44: pending, read; write-1-to-clear.
  - 0x48: overrun, sticky, read; write-1-to-clear.
  - 0x4C: active channel id in [3:0], valid bit in [31], RO.
- Writes take effect at the `clk` edge where `write_enable`=1 and the address matches. Writes to unmapped or RO addresses are ignored.
- `done[i]`=1 in a cycle sets `pending[i]`.
  - If `pending[i]` is already 1 and is not being cleared that cycle, set `overrun[i]` and pulse `error`.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if `(pending & enable) != 0`, arbitrate, latch `act_id` and `isr_addr <= table[act_id]`, set `IRQ`, go to REQ.
  - REQ: hold `IRQ`. When `IACK`=1, clear `pending[act_id]`, drop `IRQ`, advance the round-robin pointer to `act_id+1` (mod NUM_CH), go to WAIT.
  - WAIT: go to IDLE once `IACK`=0. This means one acknowledge retires only one request.
- Fixed mode: the highest set index wins. Round-robin mode: the first set index at or above the pointer wins, wrapping.
- Boundary conditions:
  - `done[act_id]` in the same cycle as the `IACK` clear: pending stays 1, no overrun.
  - Software W1C and `done` on the same bit in the same cycle: set wins.
  - Disabling or clearing the active channel during REQ does not retract `IRQ`, which stays committed until `IACK`.
  - Table writes during REQ do not change the latched `isr_addr`.
  - `IACK` in IDLE or WAIT is ignored.
- Reset values:
  - `IRQ`=0, `isr_addr`=0, `error`=0.
  - Table, pending and overrun = 0.
  - Enable = all ones.
  - Round-robin pointer = 0, FSM = IDLE.

## Timing
- `done[i]` high at edge t: pending set at t. `IRQ` and `isr_addr` are valid after edge t+1, giving 2-cycle latency from the `done` sample to `IRQ`.
- `IACK` sampled high at edge a: `IRQ` low after a. The earliest next `IRQ` is one cycle after the edge where `IACK` is sampled low.
- `read_data` is combinational from `input_addr`. Register writes are visible on `read_data` the cycle after the write edge.
- `error` is high for exactly the cycle following the offending edge.

## Structure
- Package `intc_pkg`: register offsets (`OFF_TABLE`, `OFF_ENABLE`, `OFF_PEND`, `OFF_OVR`, `OFF_ACTIVE`), FSM state enum `intc_state_t`, and the `MAX_CH`=16 constant.
- Sub-module `intc_arbiter`: combinational priority pick.
  - Inputs: request vector, round-robin pointer, mode.
  - Outputs: `grant_id`, `grant_valid`.
- Top level holds the registers, FSM and bus decode.

## Test plan
- Program the table with 0xA, 0xB, 0xC, 0xD at 0x2000–0x200C, then read back -> each `read_data` matches. An unmapped read of 0x2050 returns 0.
- Pulse `done`=4'b1000 for one cycle -> `IRQ`=1 two cycles later with `isr_addr`=0xD. Assert `IACK` -> `IRQ`=0 next cycle and pending reads 0.
- Fixed mode: `done`=4'b0101 together -> first `isr_addr`=0xC, after ack `isr_addr`=0xA. Round-robin with pointer at 3 -> 0xA first, then 0xC.
- Write enable=4'b1101, then pulse `done[1]` -> no `IRQ`, pending reads 4'b0010. Write enable=4'hF -> `IRQ` with 0xB.
- Pulse `done[2]` twice before ack -> `error` pulses once, overrun reads 4'b0100. W1C 0x4 to 0x2048 -> overrun 0.
- Hold `IACK` high across two pending channels -> only one retired until `IACK` falls. Assert `rst_n`=0 mid-REQ -> `IRQ`=0, pending=0 and enable=4'hF immediately.
